// File: rtl/seg_pkg.sv
// Shared types and segment patterns for the seven-segment scan controller.
// Segment bit order is {g,f,e,d,c,b,a}, active-high (polarity applied by the caller).
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_e;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_decode.sv
// Combinational BCD nibble to active-high segment pattern; blank_i forces all segments off.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = blank_i ? '0 : bcd_to_seg(nib_i);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller with inter-digit blanking and per-frame latching.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN darkens leading zero digits 3..1.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 25000,
  parameter int unsigned BLANK_CYC   = 250,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          DIG_ACT_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        disp_en,
  input  logic [15:0] bcd_in,
  input  logic        bcd_valid,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [3:0]  dig_out,
  output logic        frame_done
);

  localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - BLANK_CYC - 1);
  localparam logic [6:0] SEG_INV = {7{SEG_ACT_LOW}};
  localparam logic [3:0] DIG_INV = {4{DIG_ACT_LOW}};

  state_e         state_q, state_d;
  logic [1:0]     idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [15:0]    pend_q, pend_d, shadow_q, shadow_d;
  logic [3:0]     pdp_q, pdp_d, sdp_q, sdp_d;
  logic [6:0]     seg_q, seg_d;
  logic           dp_q, dp_d;
  logic [3:0]     dig_q, dig_d;
  logic           fd_q, fd_d;

  logic           load;
  logic           show;
  logic           blank;
  logic [3:0]     nib;
  logic [6:0]     seg_raw;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    fd_d     = 1'b0;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (disp_en) begin
          state_d = BLANK;
          idx_d   = '0;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            fd_d = 1'b1;
            load = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Display disable overrides every transition, including a pending frame boundary.
    if (!disp_en) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      fd_d    = 1'b0;
      load    = 1'b0;
    end
  end

  always_comb begin
    pend_d   = bcd_valid ? bcd_in : pend_q;
    pdp_d    = bcd_valid ? dp_in  : pdp_q;
    shadow_d = shadow_q;
    sdp_d    = sdp_q;
    if (load) begin
      shadow_d = bcd_valid ? bcd_in : pend_q;
      sdp_d    = bcd_valid ? dp_in  : pdp_q;
    end
  end

  always_comb begin
    nib = shadow_q[{idx_q, 2'b00} +: 4];
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [3:0] lz;
  always_comb begin
    lz[3] = (shadow_q[15:12] == 4'd0);
    lz[2] = lz[3] && (shadow_q[11:8] == 4'd0);
    lz[1] = lz[2] && (shadow_q[7:4] == 4'd0);
    lz[0] = 1'b0;
    blank = lz[idx_q];
  end
`else
  always_comb begin
    blank = 1'b0;
  end
`endif

  seg_decode u_decode (
    .nib_i   (nib),
    .blank_i (blank),
    .seg_o   (seg_raw)
  );

  // Pins reflect the current state one cycle later; disp_en low darkens them at once.
  always_comb begin
    show  = (state_q == SHOW) && disp_en;
    seg_d = (show ? seg_raw : 7'd0) ^ SEG_INV;
    dig_d = (show ? (4'd1 << idx_q) : 4'd0) ^ DIG_INV;
    dp_d  = (show && sdp_q[idx_q]) ^ SEG_ACT_LOW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      pdp_q    <= '0;
      shadow_q <= '0;
      sdp_q    <= '0;
      seg_q    <= SEG_INV;
      dp_q     <= SEG_ACT_LOW;
      dig_q    <= DIG_INV;
      fd_q     <= 1'b0;
    end else if (clk_en) begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      pdp_q    <= pdp_d;
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      dig_q    <= dig_d;
      fd_q     <= fd_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign dig_out    = dig_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-position reference model predicts the pins each clock.
module tb_seg_scan_ctrl;

  localparam int SD = 10;
  localparam int BC = 2;
  localparam int FR = 4 * SD;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] dig;
    logic       fd;
  } pins_t;

  logic        clk = 1'b0;
  logic        rst_n, clk_en, disp_en, bcd_valid;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  dig_out;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  seg_scan_ctrl #(
    .SCAN_DIV    (SD),
    .BLANK_CYC   (BC),
    .SEG_ACT_LOW (1'b1),
    .DIG_ACT_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .disp_en    (disp_en),
    .bcd_in     (bcd_in),
    .bcd_valid  (bcd_valid),
    .dp_in      (dp_in),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .dig_out    (dig_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: pins are a function of the position within the frame.
  logic [6:0]  tab [16];
  pins_t       exp_q [$];
  pins_t       last_exp;
  int          m_k = 0;
  bit          m_active = 1'b0;
  logic [15:0] m_pend = '0, m_frame = '0;
  logic [3:0]  m_pdp = '0, m_fdp = '0;

  function automatic pins_t idle_pins();
    pins_t r;
    r.seg = 7'h7F;
    r.dp  = 1'b1;
    r.dig = 4'hF;
    r.fd  = 1'b0;
    return r;
  endfunction

  function automatic pins_t scan_pins(input int p, input logic [15:0] val, input logic [3:0] dpv);
    pins_t       r;
    int          slot;
    logic [15:0] upper;
    logic [3:0]  onehot;
    logic [6:0]  pat;
    r    = idle_pins();
    slot = p / SD;
    if ((p % SD) >= BC) begin
      upper  = val >> (4 * slot);
      pat    = tab[upper[3:0]];
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (slot > 0 && upper == 16'd0) pat = 7'd0;
`endif
      onehot = 4'd1 << slot;
      r.seg  = ~pat;
      r.dig  = ~onehot;
      r.dp   = ~dpv[slot];
    end
    return r;
  endfunction

  initial begin
    tab[0] = 7'h3F; tab[1] = 7'h06; tab[2] = 7'h5B; tab[3] = 7'h4F;
    tab[4] = 7'h66; tab[5] = 7'h6D; tab[6] = 7'h7D; tab[7] = 7'h07;
    tab[8] = 7'h7F; tab[9] = 7'h6F;
    for (int i = 10; i < 16; i++) tab[i] = 7'h40;
    last_exp = idle_pins();
  end

  always @(posedge clk) begin
    pins_t e;
    e = last_exp;
    if (!rst_n) begin
      m_active = 1'b0;
      m_k      = 0;
      m_pend   = '0;
      m_pdp    = '0;
      m_frame  = '0;
      m_fdp    = '0;
      e        = idle_pins();
    end else if (clk_en) begin
      if (!disp_en) begin
        m_active = 1'b0;
        e        = idle_pins();
      end else if (!m_active) begin
        m_active = 1'b1;
        m_k      = 0;
        e        = idle_pins();
        m_frame  = bcd_valid ? bcd_in : m_pend;
        m_fdp    = bcd_valid ? dp_in : m_pdp;
      end else begin
        m_k  = m_k + 1;
        e    = scan_pins((m_k - 1) % FR, m_frame, m_fdp);
        e.fd = (m_k % FR == 0);
        if (m_k % FR == 0) begin
          m_frame = bcd_valid ? bcd_in : m_pend;
          m_fdp   = bcd_valid ? dp_in : m_pdp;
        end
      end
      if (bcd_valid) begin
        m_pend = bcd_in;
        m_pdp  = dp_in;
      end
    end
    last_exp = e;
    exp_q.push_back(e);
  end

  // Monitor: the pins are presented every cycle; compare mid-cycle.
  always @(negedge clk) begin
    pins_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.seg = seg_out;
      a.dp  = dp_out;
      a.dig = dig_out;
      a.fd  = frame_done;
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL pins t=%0t k=%0d: got seg=%b dp=%b dig=%b fd=%b, expected seg=%b dp=%b dig=%b fd=%b",
                 $time, m_k, a.seg, a.dp, a.dig, a.fd, e.seg, e.dp, e.dig, e.fd);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_slot(input int slot, input int off_min, input string tag);
    int n;
    n = 0;
    while (!(m_active && m_k >= 1 && ((m_k - 1) % FR) / SD == slot &&
             ((m_k - 1) % FR) % SD >= off_min) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_%s: slot %0d not reached, got k=%0d, expected within 400 cycles", tag, slot, m_k);
    end
  endtask

  task automatic wait_boundary();
    int n;
    n = 0;
    while (!(m_active && m_k % FR == FR - 1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_boundary: got k=%0d, expected frame end within 400 cycles", m_k);
    end
  endtask

  task automatic write(input logic [15:0] v, input logic [3:0] d);
    bcd_in    = v;
    dp_in     = d;
    bcd_valid = 1'b1;
    @(negedge clk);
    bcd_valid = 1'b0;
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < 4; i++)
      v[4*i +: 4] = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom % 16);
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; disp_en = 1'b0;
    bcd_in = '0; bcd_valid = 1'b0; dp_in = '0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);

    // Start scanning with a bypass load of 1234.
    disp_en = 1'b1;
    write(16'h1234, 4'b0100);
    cyc(90);

    // Mid-frame write only appears in the next frame.
    wait_slot(1, BC, "mid");
    write(16'h5678, 4'b0001);
    cyc(80);

    // Write on the frame-boundary cycle goes straight to the shadow.
    wait_boundary();
    write(16'h9999, 4'b1000);
    cyc(45);

    write(16'h00A5, 4'b0000);
    cyc(90);
    write(16'h0000, 4'b0011);
    cyc(45);

    // Clock-enable freeze mid-SHOW.
    wait_slot(2, BC + 3, "freeze");
    clk_en = 1'b0;
    cyc(7);
    clk_en = 1'b1;
    cyc(30);

    // Abort: display disable while scanning.
    wait_slot(3, BC + 7, "abort");
    disp_en = 1'b0;
    cyc(5);
    disp_en = 1'b1;
    cyc(50);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      bcd_valid = ($urandom % 25 == 0);
      bcd_in    = rand_bcd();
      dp_in     = 4'($urandom % 16);
      clk_en    = ($urandom % 8 != 0);
      disp_en   = ($urandom % 250 != 0);
      @(negedge clk);
    end
    bcd_valid = 1'b0;
    clk_en    = 1'b1;
    disp_en   = 1'b1;
    write(16'h4321, 4'b1111);
    cyc(20);

    // Asynchronous reset mid-SHOW of digit 2.
    wait_slot(2, BC + 2, "reset");
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (seg_out !== 7'h7F || dig_out !== 4'hF || dp_out !== 1'b1 || frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got seg=%b dig=%b dp=%b fd=%b, expected seg=1111111 dig=1111 dp=1 fd=0",
               seg_out, dig_out, dp_out, frame_done);
    end
    cyc(3);
    rst_n = 1'b1;
    cyc(60);

    cyc(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
